gpio_input_filter: RTL and testbench
====================================

# gpio_input_filter

Input conditioning stage that sits directly upstream of the GPIO controller. It takes asynchronous pad inputs and drives the controller's `gpio_in` port. Each pin passes through a multi-flop synchronizer, then an optional per-pin debounce filter clocked by a shared sample-tick prescaler. It also produces a one-cycle pulse per pin whenever the filtered value changes.

## Interface
- `WIDTH`, 64, number of GPIO pins.
- `SYNC_STAGES`, 2, synchronizer depth; at least 2.
- `PRESCALE`, 1000, clk cycles per debounce sample tick; at least 1.
- `STABLE_COUNT`, 4, consecutive differing ticks required to accept a new level; range 1..255.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `pad_in`  in  WIDTH  raw asynchronous pad levels.
- `bypass_mask`  in  WIDTH  1 = pin skips debounce and uses the synchronized value directly; quasi-static.
- `gpio_in_filt`  out  WIDTH  conditioned levels; connects to the GPIO controller's `gpio_in`.
- `edge_pulse`  out  WIDTH  1-cycle pulse on each change of `gpio_in_filt[i]`.
- `sample_tick`  out  1  registered copy of the internal prescaler tick; for debug and verification.

## Operation
- **Synchronizer:** a chain of `SYNC_STAGES` flops per pin. The last stage is `sync[i]`. All stages reset to 0.
- **Prescaler:** counter `presc` counts 0..`PRESCALE`-1 and wraps to 0.
  - Internal `tick` = (`presc` == `PRESCALE`-1).
  - `PRESCALE`=1 means `tick` is high every cycle.
  - `sample_tick` is registered from `tick`.
- **Per-pin state:** filtered level `filt[i]` and counter `cnt[i]` of width clog2(`STABLE_COUNT`+1).
- **Per-pin update each cycle, in priority order:**
  1. `bypass_mask[i]`=1: `filt[i]` <= `sync[i]`, `cnt[i]` <= 0.
  2. Else, no `tick`: hold state.
  3. Else, `tick` and `sync[i]` == `filt[i]`: `cnt[i]` <= 0. Any partial count is discarded, which is how glitches are rejected.
  4. Else, `tick` and `cnt[i]` == `STABLE_COUNT`-1: `filt[i]` <= `sync[i]`, `cnt[i]` <= 0.
  5. Else, `tick`: `cnt[i]` <= `cnt[i]`+1.
- **Outputs:**
  - `gpio_in_filt` = `filt`, driven directly from the register.
  - `edge_pulse[i]` is registered: high for exactly the one cycle in which `gpio_in_filt[i]` shows its new value.
- **Pin independence:** pins are fully independent. Simultaneous transitions on any subset of pins are each handled on their own.
- **Changing `bypass_mask[i]`:** takes effect on the next cycle. The pin's count restarts from 0 when it leaves bypass.

## Timing
- **Reset values** (rst=0 at a clk edge): all synchronizer flops, `presc`, `cnt`, `filt`, `gpio_in_filt`, `edge_pulse` and `sample_tick` are 0.
- **After reset:** the first `tick` occurs in cycle `PRESCALE`-1 after rst is released.
- **Pins high through reset:** a pin held high through reset produces one rising transition on `gpio_in_filt`, with `edge_pulse`, after release. The downstream edge detector sees this edge by design.
- **Bypass latency:** a pad change appears on `gpio_in_filt` `SYNC_STAGES`+1 cycles later. `edge_pulse` is high in that same cycle.
- **Debounce acceptance:** the level is accepted on the clk edge that ends the `STABLE_COUNT`-th consecutive tick on which `sync` differs from `filt`.
  - Latency from a stable pad change is between (`STABLE_COUNT`-1)·`PRESCALE`+`SYNC_STAGES`+1 and `STABLE_COUNT`·`PRESCALE`+`SYNC_STAGES`+1 cycles.
- **Glitch rejection:** a pulse shorter than (`STABLE_COUNT`-1)·`PRESCALE` cycles is always rejected.
- **Reset mid-count:** discards all partial counts and returns to the reset values above. There is no carry-over.

## Configuration
- Macro: `GPIO_IN_DEBOUNCE_EN`.
- **Defined:** full behaviour as described above.
- **Undefined:**
  - Prescaler and per-pin counters are not built.
  - Every pin behaves as if `bypass_mask`=all ones, so latency is `SYNC_STAGES`+1.
  - `bypass_mask` is ignored.
  - `sample_tick` is tied to 0.
  - `PRESCALE` and `STABLE_COUNT` are unused.

## Test plan
Bench parameters: `WIDTH`=64, `SYNC_STAGES`=2, `PRESCALE`=4, `STABLE_COUNT`=3, macro defined unless stated.

1. **Reset with pins high:** `pad_in`=64'hFFFF_FFFF_FFFF_FFFF held through reset -> all outputs 0 while rst=0. After release, `gpio_in_filt` goes all ones within 15 cycles, with `edge_pulse` all ones for exactly 1 cycle.
2. **Glitch rejection:** pin 5 high for 6 cycles, then low -> `gpio_in_filt[5]` stays 0 and `edge_pulse[5]` never asserts.
3. **Bypass path:** `bypass_mask[7]`=1, `pad_in[7]` toggles every 10 cycles -> `gpio_in_filt[7]` follows exactly 3 cycles after each toggle, with one `edge_pulse[7]` per toggle.
4. **Bounce then settle:** pin 12 toggles every 5 cycles for 40 cycles, then stays 1 -> exactly one rising transition, within 15 cycles of settling. No other pin changes.
5. **Reset mid-count:** pin 20 held high for 2 ticks, then rst=0 for 1 cycle, then pad left high -> `cnt` is cleared and the rise occurs ≥9 cycles after release, not earlier.
6. **Macro undefined:** random `pad_in` patterns -> `gpio_in_filt` equals `pad_in` delayed by 3 cycles on all 64 pins, and `sample_tick` stays 0.

Source files
------------

// File: rtl/gpio_input_filter_if.sv
// Pad-side bundle between the GPIO pads and the input conditioning stage.
// Master is the pad/stimulus side and slave is the filter.
interface gpio_input_filter_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] bypass_mask;
    logic [WIDTH-1:0] gpio_in_filt;
    logic [WIDTH-1:0] edge_pulse;
    logic             sample_tick;

    modport master (
        output pad_in,
        output bypass_mask,
        input  gpio_in_filt,
        input  edge_pulse,
        input  sample_tick
    );

    modport slave (
        input  pad_in,
        input  bypass_mask,
        output gpio_in_filt,
        output edge_pulse,
        output sample_tick
    );
endinterface

// File: rtl/gpio_input_filter.sv
// GPIO input conditioning: per-pin synchronizer, optional tick-sampled debounce
// (enabled by GPIO_IN_DEBOUNCE_EN) and a one-cycle pulse on each filtered change.
module gpio_input_filter #(
    parameter int WIDTH        = 64,
    parameter int SYNC_STAGES  = 2,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_COUNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    gpio_input_filter_if.slave  io
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  filt_p1;
    logic [WIDTH-1:0]                  filt_nxt;
    logic [WIDTH-1:0]                  pulse_p1;

    // Stage 0: synchronizer chain, newest sample in element 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], io.pad_in};
        end
    end

    assign sync = sync_p0[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W   = $clog2(STABLE_COUNT + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_COUNT - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               sample_tick_p1;
    logic [CNT_W-1:0]   cnt     [WIDTH];
    logic [CNT_W-1:0]   cnt_nxt [WIDTH];

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc          <= '0;
            sample_tick_p1 <= 1'b0;
            cnt            <= '{default: '0};
        end else begin
            presc          <= tick ? '0 : presc + 1'b1;
            sample_tick_p1 <= tick;
            cnt            <= cnt_nxt;
        end
    end

    // A tick that finds sync equal to filt throws away any partial run.
    always_comb begin
        filt_nxt = filt_p1;
        cnt_nxt  = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (io.bypass_mask[i]) begin
                filt_nxt[i] = sync[i];
                cnt_nxt[i]  = '0;
            end else if (tick) begin
                if (sync[i] == filt_p1[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt_nxt[i] = sync[i];
                    cnt_nxt[i]  = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign io.sample_tick = sample_tick_p1;
`else
    localparam int unused_cfg = PRESCALE + STABLE_COUNT;

    logic unused_bypass;

    assign unused_bypass  = ^io.bypass_mask;
    assign filt_nxt       = sync;
    assign io.sample_tick = 1'b0;
`endif

    // Stage 1: filtered level and its change pulse land on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_p1  <= '0;
            pulse_p1 <= '0;
        end else begin
            filt_p1  <= filt_nxt;
            pulse_p1 <= filt_nxt ^ filt_p1;
        end
    end

    assign io.gpio_in_filt = filt_p1;
    assign io.edge_pulse   = pulse_p1;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Scoreboard bench for gpio_input_filter: stimulus queues expected edge events,
// a negedge monitor pops and compares them whenever edge_pulse is nonzero.
module tb_gpio_input_filter;
    localparam int W = 64;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam bit DEB  = 1'b1;
    localparam int RISE = 12;
`else
    localparam bit DEB  = 1'b0;
    localparam int RISE = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpio_input_filter_if #(.WIDTH(W)) bus ();

    gpio_input_filter #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .PRESCALE    (4),
        .STABLE_COUNT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct {
        logic [W-1:0] pulse;
        logic [W-1:0] filt;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   t0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [W-1:0] pulse,
                        input logic [W-1:0] filt, input int at);
        exp_t e;
        e.name  = name;
        e.pulse = pulse;
        e.filt  = filt;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.edge_pulse !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_edge", bus.edge_pulse, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_pulse"}, bus.edge_pulse, e.pulse);
                chk({e.name, "_filt"}, bus.gpio_in_filt, e.filt);
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_rel(input int d);
        while (cyc - t0 < d) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_filt", bus.gpio_in_filt, '0);
        chk("rst_edge", bus.edge_pulse, '0);
        chk("rst_tick", {63'b0, bus.sample_tick}, '0);
        rst = 1'b1;
        t0  = cyc;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), '0);
    endtask

    logic [W-1:0] vec_tbl [8] = '{
        64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000,
        64'h8000_0000_0000_0001, 64'hAAAA_AAAA_5555_5555, 64'h0000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_F0F0_1234_8765
    };

    initial begin
        bus.pad_in      = '0;
        bus.bypass_mask = '0;

        // Test 1: pins high through reset
        bus.pad_in = '1;
        do_reset(3);
        push("t1_rise", '1, '1, t0 + RISE);
        wait_rel(2);
        chk("t1_pre_filt", bus.gpio_in_filt, '0);
        wait_rel(3);
        chk("t1_tick3", {63'b0, bus.sample_tick}, '0);
        wait_rel(4);
        chk("t1_tick4", {63'b0, bus.sample_tick}, {63'b0, DEB});
        wait_rel(5);
        chk("t1_tick5", {63'b0, bus.sample_tick}, '0);
        wait_rel(20);
        chk("t1_filt", bus.gpio_in_filt, '1);
        settle();

        // Test 3: bypass on pin 7
        bus.pad_in = '0;
        do_reset(2);
        bus.bypass_mask = 64'h80;
        for (int k = 1; k <= 4; k++) begin
            wait_rel(10 * k);
            bus.pad_in[7] = ~bus.pad_in[7];
            push("t3_edge", 64'h80, bus.pad_in, cyc + 3);
        end
        wait_rel(50);
        chk("t3_filt", bus.gpio_in_filt, '0);
        bus.bypass_mask = '0;
        settle();

`ifdef GPIO_IN_DEBOUNCE_EN
        // Test 2: 6-cycle glitches on pin 5 at two prescaler phases
        bus.pad_in = '0;
        do_reset(2);
        wait_rel(9);
        bus.pad_in[5] = 1'b1;
        wait_rel(15);
        bus.pad_in[5] = 1'b0;
        wait_rel(41);
        bus.pad_in[5] = 1'b1;
        wait_rel(47);
        bus.pad_in[5] = 1'b0;
        wait_rel(70);
        chk("t2_filt", bus.gpio_in_filt, '0);
        settle();

        // Test 4: pin 12 bounces every 5 cycles, then settles high
        bus.pad_in = '0;
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            wait_rel(10 + 5 * k);
            bus.pad_in[12] = (k % 2 == 0);
        end
        wait_rel(50);
        bus.pad_in[12] = 1'b1;
        push("t4_settle", 64'h1000, 64'h1000, t0 + 64);
        wait_rel(80);
        chk("t4_filt", bus.gpio_in_filt, 64'h1000);
        settle();

        // Test 5: reset after two counted ticks on pin 20
        bus.pad_in = '0;
        do_reset(2);
        bus.pad_in[20] = 1'b1;
        wait_rel(8);
        chk("t5_pre_filt", bus.gpio_in_filt, '0);
        do_reset(1);
        push("t5_rise", 64'h10_0000, 64'h10_0000, t0 + 12);
        wait_rel(30);
        chk("t5_filt", bus.gpio_in_filt, 64'h10_0000);
        settle();
`else
        // Test 6: every pin follows pad_in three cycles later
        begin
            logic [W-1:0] prev;
            logic [W-1:0] v;
            bus.pad_in = '0;
            do_reset(2);
            prev = '0;
            for (int i = 0; i < 12; i++) begin
                wait_rel(5 + i);
                v = (i < 8) ? vec_tbl[i] : {$urandom, $urandom};
                if (v != prev) push("t6_vec", v ^ prev, v, cyc + 3);
                bus.pad_in = v;
                prev       = v;
                chk("t6_tick", {63'b0, bus.sample_tick}, '0);
            end
            wait_rel(40);
            chk("t6_filt", bus.gpio_in_filt, prev);
            settle();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
